// File: rtl/regfile_pkg.sv
// Shared constants, clear-engine state encoding and port-slicing helper for the
// multi-port register file used by the decode stage.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 32;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

  // Bit offset of port `port` inside a packed bus of `width`-bit fields.
  function automatic int port_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Per-read-port source select: hard zero, then write port 0, then write port 1,
// then the stored array value.
module regfile_bypass #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [DATA_W-1:0] arr_data,
  output logic [DATA_W-1:0] data
);

  // NOTE: assign a default before any branch so no path leaves data unassigned (no latch).
  always_comb begin
    data = arr_data;
    if (ZERO_REG != 0 && addr == '0) begin
      data = '0;
    end else if (we0 && wa0 == addr) begin
      data = wd0;
    end else if (we1 && wa1 == addr) begin
      data = wd1;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered write-first read ports, two
// prioritised write ports, optional zero register, debug tap, bulk-clear engine.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic                     clr_req,
  output logic                     clr_busy,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_next [NUM_RD];
  clr_state_e        state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic              clearing;
  logic              we0_eff, we1_eff;

  assign clearing = (state == CLR_CLEAR);
  assign clr_busy = clearing;

  // User writes are masked during a sweep and dropped at the hard-zero index;
  // the masked enables also gate the bypass.
  assign we0_eff = we0 && !clearing && !(ZERO_REG != 0 && wa0 == '0);
  assign we1_eff = we1 && !clearing && !(ZERO_REG != 0 && wa1 == '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      CLR_IDLE: begin
        if (clr_req) begin
          state_n = CLR_CLEAR;
          cnt_n   = '0;
        end
      end
      CLR_CLEAR: begin
        cnt_n = cnt + ADDR_W'(1);
        if (cnt == LAST_IDX) state_n = CLR_IDLE;
      end
      default: state_n = CLR_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLR_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // NOTE: the array is deliberately reset; contents must read zero right after reset, even mid-sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clearing) begin
      mem[cnt] <= '0;
    end else begin
      // Port 0 is written last so it wins an address collision.
      if (we1_eff) mem[wa1] <= wd1;
      if (we0_eff) mem[wa0] <= wd0;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    localparam int ALSB = port_lsb(k, ADDR_W);
    logic [ADDR_W-1:0] addr;

    assign addr = rd_addr[ALSB +: ADDR_W];

    regfile_bypass #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_bypass (
      .addr    (addr),
      .we0     (we0_eff),
      .wa0     (wa0),
      .wd0     (wd0),
      .we1     (we1_eff),
      .wa1     (wa1),
      .wd1     (wd1),
      .arr_data(mem[addr]),
      .data    (rd_next[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) rd_data[port_lsb(k, DATA_W) +: DATA_W] <= rd_next[k];
    end
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed vector table, clear/reset
// sequences, and randomised traffic against an array-based reference model.
module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data, rd_data_nz;
  logic              we0, we1, clr_req;
  logic [AW-1:0]     wa0, wa1, dbg_addr;
  logic [DW-1:0]     wd0, wd1, dbg_data, dbg_data_nz;
  logic              clr_busy, clr_busy_nz;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stored contents plus remaining sweep length and position.
  logic [DW-1:0] model [DEPTH];
  int            clr_left;
  int            clr_pos;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .clr_req(clr_req), .clr_busy(clr_busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  regfile_mp #(.DATA_W(DW), .DEPTH(DEPTH), .NUM_RD(NRD), .ZERO_REG(0)) dut_nz (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nz),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .clr_req(clr_req), .clr_busy(clr_busy_nz), .dbg_addr(dbg_addr), .dbg_data(dbg_data_nz)
  );

  typedef struct {
    logic          we0;
    logic [AW-1:0] wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd1;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] exp0;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp_nz0;
    logic [DW-1:0] dbg8_pre;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] predict(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (clr_left == 0 && we0 && wa0 == a) return wd0;
    if (clr_left == 0 && we1 && wa1 == a) return wd1;
    return model[a];
  endfunction

  // Apply current inputs for one clock edge, advance the model, compare outputs.
  task automatic step();
    logic [DW-1:0] e [NRD];
    for (int k = 0; k < NRD; k++) e[k] = predict(rd_addr[k*AW +: AW]);
    if (clr_left > 0) begin
      model[clr_pos] = '0;
      clr_pos++;
      clr_left--;
    end else begin
      if (we1 && wa1 != 0) model[wa1] = wd1;
      if (we0 && wa0 != 0) model[wa0] = wd0;
      if (clr_req) begin
        clr_left = DEPTH;
        clr_pos  = 0;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NRD; k++) check($sformatf("rd%0d", k), rd_data[k*DW +: DW], e[k]);
    check("clr_busy", DW'(clr_busy), DW'(clr_left > 0));
    check("dbg_data", dbg_data, model[dbg_addr]);
  endtask

  task automatic idle_inputs();
    we0 = 0; wa0 = '0; wd0 = '0;
    we1 = 0; wa1 = '0; wd1 = '0;
    clr_req = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    clr_left = 0;
    clr_pos  = 0;
  endtask

  task automatic read_all_zero(input string name);
    idle_inputs();
    for (int i = 0; i < DEPTH / 2; i++) begin
      rd_addr = {AW'(i + DEPTH / 2), AW'(i)};
      step();
      check($sformatf("%s_lo%0d", name, i), rd_data[DW-1:0], '0);
      check($sformatf("%s_hi%0d", name, i + DEPTH / 2), rd_data[2*DW-1:DW], '0);
    end
  endtask

  // Pulses clr_req and counts busy samples, with a bounded wait.
  task automatic sweep_len(input string name, input bit poke);
    int busy_cnt;
    busy_cnt = 0;
    clr_req = 1;
    step();
    clr_req = 0;
    for (int t = 0; t < 40 && clr_busy; t++) begin
      busy_cnt++;
      if (poke && t == 5) clr_req = 1;
      if (poke && t == 10) begin
        we0 = 1; wa0 = 20; wd0 = 32'h55;
        rd_addr = {AW'(21), AW'(20)};
      end
      step();
      clr_req = 0;
      we0 = 0;
    end
    check(name, DW'(busy_cnt), DW'(DEPTH));
  endtask

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0};
    vecs[1]  = '{1, 8, 32'hDEAD_BEEF, 0, 0, 0, 8, 8, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 0, 8, 9, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3]  = '{1, 9, 1, 1, 9, 2, 9, 9, 1, 1, 1, 32'hDEAD_BEEF};
    vecs[4]  = '{0, 0, 0, 0, 0, 0, 9, 8, 1, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
    vecs[5]  = '{0, 0, 0, 1, 9, 3, 9, 8, 3, 32'hDEAD_BEEF, 3, 32'hDEAD_BEEF};
    vecs[6]  = '{0, 0, 0, 0, 0, 0, 9, 9, 3, 3, 3, 32'hDEAD_BEEF};
    vecs[7]  = '{1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 9, 0, 3, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
    vecs[8]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
    vecs[9]  = '{1, 10, 32'hA5A5_A5A5, 1, 11, 32'h5A5A_5A5A, 11, 10, 32'h5A5A_5A5A, 32'hA5A5_A5A5,
                 32'h5A5A_5A5A, 32'hDEAD_BEEF};
    vecs[10] = '{1, 12, 32'h77, 1, 0, 32'h1234_5678, 0, 12, 0, 32'h77, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[11] = '{0, 0, 0, 0, 0, 0, 0, 11, 0, 32'h5A5A_5A5A, 32'h1234_5678, 32'hDEAD_BEEF};

    idle_inputs();
    rd_addr  = '0;
    dbg_addr = 8;
    model_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", DW'(clr_busy), '0);
    check("rst_rd", rd_data[DW-1:0], '0);
    rst_n = 1;

    // Directed vectors: bypass, collision, zero register.
    for (int i = 0; i < 12; i++) begin
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      rd_addr = {vecs[i].a1, vecs[i].a0};
      #1;
      check($sformatf("vec%0d_dbg8_pre", i), dbg_data, vecs[i].dbg8_pre);
      step();
      check($sformatf("vec%0d_p0", i), rd_data[DW-1:0], vecs[i].exp0);
      check($sformatf("vec%0d_p1", i), rd_data[2*DW-1:DW], vecs[i].exp1);
      check($sformatf("vec%0d_nz_p0", i), rd_data_nz[DW-1:0], vecs[i].exp_nz0);
    end
    idle_inputs();

    // Bulk clear with a re-request and a masked write mid-sweep.
    for (int i = 0; i < DEPTH; i++) begin
      we0 = 1; wa0 = AW'(i); wd0 = DW'(i + 1);
      rd_addr = {AW'(i), AW'(i)};
      step();
    end
    idle_inputs();
    rd_addr = {AW'(31), AW'(7)};
    step();
    check("fill_7", rd_data[DW-1:0], 32'd8);
    sweep_len("clr_len", 1'b1);
    read_all_zero("clr_rd");

    // Reset during a sweep.
    for (int i = 1; i < 6; i++) begin
      we0 = 1; wa0 = AW'(i); wd0 = 32'hC0DE_0000 | DW'(i);
      step();
    end
    idle_inputs();
    clr_req = 1;
    step();
    clr_req = 0;
    repeat (9) step();
    check("pre_rst_busy", DW'(clr_busy), 32'd1);
    rst_n = 0;
    #2;
    check("mid_rst_busy", DW'(clr_busy), '0);
    check("mid_rst_rd0", rd_data[DW-1:0], '0);
    for (int i = 1; i < 6; i++) begin
      dbg_addr = AW'(i);
      #1;
      check($sformatf("mid_rst_dbg%0d", i), dbg_data, '0);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    read_all_zero("rst_rd");
    sweep_len("rst_clr_len", 1'b0);

    // Randomised traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      wa0 = AW'($urandom_range(0, 7));
      wa1 = AW'($urandom_range(0, 7));
      wd0 = $urandom;
      wd1 = $urandom;
      rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, DEPTH - 1))};
      dbg_addr = AW'($urandom_range(0, DEPTH - 1));
      clr_req = ($urandom_range(0, 59) == 0);
      step();
    end
    idle_inputs();
    for (int t = 0; t < 40 && clr_left > 0; t++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
